// File: rtl/timer_key_loader_if.sv
// Keypad/counter-side bundle for timer_key_loader: key strobes and start/cancel/enable in,
// BCD load data, load strobe and entry status out.
interface timer_key_loader_if;
    logic       key_valid;
    logic [3:0] key_data;
    logic       startn;
    logic       cancel;
    logic       en;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] mins;
    logic       loadn;
    logic [1:0] digit_count;
    logic       full;
    logic       err;

    modport master (
        output key_valid, key_data, startn, cancel, en,
        input  sec_ones, sec_tens, mins, loadn, digit_count, full, err
    );

    modport slave (
        input  key_valid, key_data, startn, cancel, en,
        output sec_ones, sec_tens, mins, loadn, digit_count, full, err
    );
endinterface

// File: rtl/timer_key_loader.sv
// Collects keypad digits into an M:SS buffer, validates the seconds-tens digit and
// drives the active-low parallel load of the countdown counter chain.
module timer_key_loader #(
    parameter int MAX_TENS    = 5,
    parameter int LOAD_CYCLES = 1
) (
    input logic                clock,
    input logic                clearn,
    timer_key_loader_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ENTRY, LOAD, WAIT_RUN} state_t;

    localparam logic [1:0] LOAD_INIT  = 2'(LOAD_CYCLES - 1);
    localparam logic [3:0] TENS_LIMIT = 4'(MAX_TENS);

    state_t     state;
    logic [1:0] load_cnt;
    logic       startn_q;
    logic       start_edge;

    // A held startn counts as one request, so an illegal start raises err only once.
    assign start_edge = !bus.startn && startn_q;
    assign bus.full   = (bus.digit_count == 2'd3);

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            state           <= IDLE;
            load_cnt        <= 2'd0;
            startn_q        <= 1'b1;
            bus.sec_ones    <= 4'd0;
            bus.sec_tens    <= 4'd0;
            bus.mins        <= 4'd0;
            bus.loadn       <= 1'b1;
            bus.digit_count <= 2'd0;
            bus.err         <= 1'b0;
        end else begin
            startn_q <= bus.startn;
            bus.err  <= 1'b0;
            if (bus.cancel) begin
                bus.sec_ones    <= 4'd0;
                bus.sec_tens    <= 4'd0;
                bus.mins        <= 4'd0;
                bus.digit_count <= 2'd0;
                bus.loadn       <= 1'b1;
                state           <= bus.en ? WAIT_RUN : IDLE;
            end else begin
                case (state)
                    IDLE, ENTRY: begin
                        if (!bus.en) begin
                            if (state == ENTRY && start_edge) begin
                                if (bus.sec_tens > TENS_LIMIT) begin
                                    bus.err <= 1'b1;
                                end else begin
                                    state     <= LOAD;
                                    bus.loadn <= 1'b0;
                                    load_cnt  <= LOAD_INIT;
                                end
                            end else if (bus.key_valid) begin
                                if (bus.key_data > 4'd9 || bus.full) begin
                                    bus.err <= 1'b1;
                                end else begin
                                    bus.mins        <= bus.sec_tens;
                                    bus.sec_tens    <= bus.sec_ones;
                                    bus.sec_ones    <= bus.key_data;
                                    bus.digit_count <= bus.digit_count + 2'd1;
                                    state           <= ENTRY;
                                end
                            end
                        end
                    end
                    LOAD: begin
                        // Counters ignore load while enabled, so en aborts the strobe early.
                        if (bus.en || load_cnt == 2'd0) begin
                            bus.loadn       <= 1'b1;
                            bus.sec_ones    <= 4'd0;
                            bus.sec_tens    <= 4'd0;
                            bus.mins        <= 4'd0;
                            bus.digit_count <= 2'd0;
                            state           <= bus.en ? WAIT_RUN : IDLE;
                        end else begin
                            load_cnt <= load_cnt - 2'd1;
                        end
                    end
                    WAIT_RUN: begin
                        if (!bus.en) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
